handshake_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one downstream ready/valid channel (and its 4-bit reduction datapath) among N upstream ready/valid requesters, matching the handshake_arr_0..2 requester set feeding the RTL handshake.
- Selects one requester per cycle and registers its payload into a single output stage.
- Also registers OR-reduce and AND-reduce of the selected payload, and counts completed downstream transfers.
- Sits between the requester array and the shared handshake consumer.

---
 rtl/handshake_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_handshake_rr_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter
// Round-robin arbiter that funnels N ready/valid requesters into one
// registered output stage. The stage also carries the source index, the
// OR/AND reductions of the payload, and a count of downstream transfers.
module handshake_rr_arbiter #(
  parameter  int N      = 3,
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 8,
  localparam int SRC_W  = $clog2(N)
) (
  input  logic                CLK,
  input  logic                ASYNCRESET,
  input  logic [N-1:0]        in_valid,
  output logic [N-1:0]        in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [SRC_W-1:0]    out_src,
  output logic                out_orr,
  output logic                out_andr,
  output logic [CNT_W-1:0]    xfer_count
);

  logic                load_en;
  logic                up_xfer;
  logic                dn_xfer;
  logic                grant_any;
  logic [N-1:0]        grant;
  logic [N-1:0]        rot_valid;
  logic [2*N-1:0]      dbl_valid;
  logic [SRC_W-1:0]    start_idx;
  logic [SRC_W-1:0]    grant_offset;
  logic [SRC_W:0]      wrap_sum;
  logic [SRC_W-1:0]    grant_idx;
  logic [DATA_W-1:0]   sel_data;
  logic [DATA_W-1:0]   payload [N];

  logic                out_valid_reg;
  logic [DATA_W-1:0]   out_data_reg;
  logic [SRC_W-1:0]    out_src_reg;
  logic                out_orr_reg;
  logic                out_andr_reg;
  logic [CNT_W-1:0]    xfer_count_reg;
  logic [SRC_W-1:0]    last_grant_reg;

  // The stage can take a new payload when empty or when it is being drained.
  assign load_en = ~out_valid_reg | out_ready;
  assign dn_xfer = out_valid_reg & out_ready;
  assign up_xfer = grant_any & load_en;

  // Per-requester payload slices and ready; ready is held low while in reset
  // so no upstream handshake can appear to complete during reset.
  for (genvar gi = 0; gi < N; gi++) begin : g_req
    assign payload[gi]  = in_data[gi*DATA_W +: DATA_W];
    assign in_ready[gi] = grant[gi] & load_en & ~ASYNCRESET;
  end

  // Search starts one past the last granted requester, wrapping at N.
  always_comb begin
    if (last_grant_reg == SRC_W'(N - 1)) begin
      start_idx = '0;
    end else begin
      start_idx = last_grant_reg + SRC_W'(1);
    end
  end

  // Rotate valids so the search origin sits at bit 0, pick the lowest set
  // bit, then map the offset back to an absolute requester index.
  always_comb begin
    dbl_valid    = {in_valid, in_valid};
    rot_valid    = N'(dbl_valid >> start_idx);
    grant_any    = 1'b0;
    grant_offset = '0;
    for (int k = 0; k < N; k++) begin
      if (!grant_any && rot_valid[k]) begin
        grant_any    = 1'b1;
        grant_offset = SRC_W'(k);
      end
    end
    wrap_sum = {1'b0, start_idx} + {1'b0, grant_offset};
    if (wrap_sum >= (SRC_W + 1)'(N)) begin
      wrap_sum = wrap_sum - (SRC_W + 1)'(N);
    end
    grant_idx = wrap_sum[SRC_W-1:0];
    grant     = grant_any ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

  // Payload mux driven by the one-hot grant.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) begin
        sel_data = payload[k];
      end
    end
  end

  // Output stage: load on upstream transfer, empty on drain-only cycles.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_src_reg    <= '0;
      out_orr_reg    <= 1'b0;
      out_andr_reg   <= 1'b0;
      last_grant_reg <= SRC_W'(N - 1);
    end else if (up_xfer) begin
      out_valid_reg  <= 1'b1;
      out_data_reg   <= sel_data;
      out_src_reg    <= grant_idx;
      out_orr_reg    <= |sel_data;
      out_andr_reg   <= &sel_data;
      last_grant_reg <= grant_idx;
    end else if (dn_xfer) begin
      out_valid_reg  <= 1'b0;
    end
  end

  // Count completed downstream transfers, wrapping naturally.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      xfer_count_reg <= '0;
    end else if (dn_xfer) begin
      xfer_count_reg <= xfer_count_reg + CNT_W'(1);
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_src    = out_src_reg;
  assign out_orr    = out_orr_reg;
  assign out_andr   = out_andr_reg;
  assign xfer_count = xfer_count_reg;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// tb_handshake_rr_arbiter
// Directed scenarios plus a randomized run, checked against a behavioural
// round-robin model. A second instance with a 2-bit counter covers wrap.
module tb_handshake_rr_arbiter;

  localparam int N  = 3;
  localparam int DW = 4;

  logic          CLK;
  logic          ASYNCRESET;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N*DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          out_orr;
  logic          out_andr;
  logic [7:0]    xfer_count;

  logic [N-1:0]  in_valid2;
  logic [N-1:0]  in_ready2;
  logic [N*DW-1:0] in_data2;
  logic          out_valid2;
  logic          out_ready2;
  logic [DW-1:0] out_data2;
  logic [1:0]    out_src2;
  logic          out_orr2;
  logic          out_andr2;
  logic [1:0]    xfer_count2;

  handshake_rr_arbiter #(.N(N), .DATA_W(DW), .CNT_W(8)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_orr(out_orr), .out_andr(out_andr),
    .xfer_count(xfer_count)
  );

  handshake_rr_arbiter #(.N(N), .DATA_W(DW), .CNT_W(2)) dut_wrap (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_src(out_src2), .out_orr(out_orr2), .out_andr(out_andr2),
    .xfer_count(xfer_count2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int m_valid, m_data, m_src, m_cnt, m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_src = 0; m_cnt = 0; m_last = N - 1;
  endtask

  // First valid requester after the last grant, wrapping; -1 when none.
  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (((in_valid >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  function automatic int payload_of(input int i);
    return int'((in_data >> (i * DW)) & 'hF);
  endfunction

  task automatic check_now();
    int g;
    int load;
    g    = pick();
    load = (m_valid == 0 || out_ready) ? 1 : 0;
    chk("in_ready", 32'(in_ready), (g >= 0 && load == 1) ? 32'(1 << g) : 32'd0);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid != 0) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_src", 32'(out_src), 32'(m_src));
      chk("out_orr", 32'(out_orr), (m_data != 0) ? 32'd1 : 32'd0);
      chk("out_andr", 32'(out_andr), (m_data == 15) ? 32'd1 : 32'd0);
    end
    chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
    $display("t=%0t in_valid=%b out_ready=%b in_ready=%b out_valid=%b src=%0d data=%h cnt=%0d",
             $time, in_valid, out_ready, in_ready, out_valid, out_src, out_data, xfer_count);
  endtask

  // One clock: check current outputs, advance the model across the edge.
  task automatic cycle();
    int g;
    int load;
    int dn;
    int pd;
    #1;
    check_now();
    g    = pick();
    load = (m_valid == 0 || out_ready) ? 1 : 0;
    dn   = (m_valid != 0 && out_ready) ? 1 : 0;
    pd   = (g >= 0) ? payload_of(g) : 0;
    @(posedge CLK);
    if (dn == 1) m_cnt = (m_cnt + 1) % 256;
    if (g >= 0 && load == 1) begin
      m_valid = 1; m_data = pd; m_src = g; m_last = g;
    end else if (dn == 1) begin
      m_valid = 0;
    end
    @(negedge CLK);
  endtask

  initial begin
    ASYNCRESET = 1'b1;
    in_valid = '0; in_data = '0; out_ready = 1'b0;
    in_valid2 = '0; in_data2 = '0; out_ready2 = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    check_now();
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_out_orr", 32'(out_orr), 32'd0);
    chk("rst_out_andr", 32'(out_andr), 32'd0);
    ASYNCRESET = 1'b0;
    @(negedge CLK);

    // Round robin with all requesters valid
    in_valid = 3'b111; in_data = {4'h3, 4'h2, 4'h1}; out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cycle();
      chk("rr_src", 32'(out_src), 32'(k % 3));
    end
    chk("rr_count", 32'(xfer_count), 32'd6);

    // Backpressure holding 4'hF from requester 2
    in_valid = 3'b100; in_data = {4'hF, 4'h2, 4'h1};
    cycle();
    out_ready = 1'b0; in_valid = 3'b111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_data", 32'(out_data), 32'hF);
      chk("bp_src", 32'(out_src), 32'd2);
      chk("bp_orr_andr", {30'd0, out_orr, out_andr}, 32'd3);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_next_src", 32'(out_src), 32'd0);
    chk("bp_count", 32'(xfer_count), 32'd8);

    // Single sparse requester with zero payload
    in_valid = 3'b010; in_data = {4'h3, 4'h0, 4'h1};
    cycle();
    chk("sparse_src", 32'(out_src), 32'd1);
    chk("sparse_red", {30'd0, out_orr, out_andr}, 32'd0);
    in_valid = 3'b000;
    cycle();
    chk("sparse_drain", 32'(out_valid), 32'd0);

    // Pointer skip: after granting 0, requester 2 beats 0
    in_valid = 3'b001;
    cycle();
    in_valid = 3'b101;
    cycle();
    chk("skip_src", 32'(out_src), 32'd2);
    cycle();
    chk("skip_wrap_src", 32'(out_src), 32'd0);

    // Reset mid-operation while the stage is full
    in_valid = 3'b010; out_ready = 1'b0;
    cycle();
    #1;
    ASYNCRESET = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(xfer_count), 32'd0);
    chk("midrst_src", 32'(out_src), 32'd0);
    model_reset();
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    in_valid = 3'b111; out_ready = 1'b1;
    cycle();
    chk("postrst_src", 32'(out_src), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      in_valid  = N'($urandom_range(0, 7));
      in_data   = (N*DW)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Counter wrap on the 2-bit instance
    in_valid = '0; out_ready = 1'b1;
    in_valid2 = 3'b001; in_data2 = {4'h0, 4'h0, 4'h5}; out_ready2 = 1'b1;
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("wrap_count", 32'(xfer_count2), 32'((k + 1) % 4));
    end

    #1;
    check_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
